// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the main-memory port and the arbiter.
// The arbiter takes the slave view; caches and memory together form the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // I-cache side
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_data_valid;
    // D-cache side
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_data_valid;
    // shared read data
    logic [DATA_W-1:0] rdata;
    // memory side
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_valid, mem_rdata,
        output i_gnt, i_data_valid, d_gnt, d_data_valid, rdata,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_valid, mem_rdata,
        input  i_gnt, i_data_valid, d_gnt, d_data_valid, rdata,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin owner arbiter for the single main-memory port shared by the
// I-cache fill FSM and the D-cache. One cache owns the port for a whole
// transaction; the grant is held until every outstanding read has returned.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 4,
    parameter int MAX_OUT     = 8
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t            state;
    logic              last_d;     // 1 when the D-cache owned the previous transaction
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              i_gnt_r;
    logic              d_gnt_r;

    logic              owner_req;
    logic              owner_wr;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              rd_fwd;
    logic              dv_ok;

    // Forward the owner's request to memory; nothing leaves the arbiter in IDLE.
    always_comb begin
        owner_req = 1'b0;
        owner_wr  = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        case (state)
            OWN_I: begin
                owner_req = bus.i_req;
                addr_sel  = bus.i_addr;
            end
            OWN_D: begin
                owner_req = bus.d_req;
                owner_wr  = bus.d_wr;
                addr_sel  = bus.d_addr;
                wdata_sel = bus.d_wdata;
            end
            default: ;
        endcase
        // Only reads expect a response; a valid with nothing outstanding is stray and dropped.
        rd_fwd   = owner_req & ~owner_wr;
        dv_ok    = bus.mem_data_valid & (out_cnt != '0);
        cnt_next = out_cnt + {{(CNT_W-1){1'b0}}, rd_fwd} - {{(CNT_W-1){1'b0}}, dv_ok};
    end

    assign bus.mem_en       = owner_req;
    assign bus.mem_wr       = owner_wr;
    assign bus.mem_addr     = addr_sel;
    assign bus.mem_wdata    = wdata_sel;
    assign bus.i_gnt        = i_gnt_r;
    assign bus.d_gnt        = d_gnt_r;
    assign bus.i_data_valid = dv_ok & (state == OWN_I);
    assign bus.d_data_valid = dv_ok & (state == OWN_D);
    assign bus.rdata        = rst ? '0 : bus.mem_rdata;

    // Ownership FSM with registered grants and the outstanding-read counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            out_cnt <= '0;
            i_gnt_r <= 1'b0;
            d_gnt_r <= 1'b0;
        end else begin
            out_cnt <= cnt_next;
            case (state)
                IDLE: begin
                    // On contention the cache that did not own the port last wins.
                    if (bus.d_req && (!bus.i_req || !last_d)) begin
                        state   <= OWN_D;
                        d_gnt_r <= 1'b1;
                    end else if (bus.i_req) begin
                        state   <= OWN_I;
                        i_gnt_r <= 1'b1;
                    end
                end
                OWN_I: begin
                    if (!owner_req && cnt_next == '0) begin
                        state   <= IDLE;
                        i_gnt_r <= 1'b0;
                        last_d  <= 1'b0;
                    end
                end
                OWN_D: begin
                    if (!owner_req && cnt_next == '0) begin
                        state   <= IDLE;
                        d_gnt_r <= 1'b0;
                        last_d  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    i_gnt_r <= 1'b0;
                    d_gnt_r <= 1'b0;
                end
            endcase
        end
    end

    // Simulation guard: a read beyond MAX_OUT outstanding is a requester bug;
    // a zero latency would let a response coincide with its own request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (MEM_LATENCY > 0 && !(rd_fwd && out_cnt == CNT_MAX));
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-accurate memory model, a
// transaction-level ownership model checked every cycle, and literal
// expectations for each scenario.
module tb_mem_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 4;
    localparam int MO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .MAX_OUT(MO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // ---------------- memory model: read response LAT cycles after issue ----------------
    logic          rec_rd = 1'b0;
    logic [DW-1:0] rec_d  = '0;
    logic          pv [LAT];
    logic [DW-1:0] pd [LAT];

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata      = '0;
        forever begin
            @(negedge clk);
            rec_rd = bus.mem_en && !bus.mem_wr;
            rec_d  = mem_word(bus.mem_addr);
            @(posedge clk);
            #2;
            for (int i = 0; i < LAT - 1; i++) begin
                pv[i] = pv[i+1];
                pd[i] = pd[i+1];
            end
            pv[LAT-1] = rec_rd;
            pd[LAT-1] = rec_d;
            bus.mem_data_valid = pv[0];
            bus.mem_rdata      = pd[0];
        end
    end

    // ---------------- ownership model and per-cycle compare ----------------
    int            m_owner = 0;  // 0 none, 1 I-cache, 2 D-cache
    bit            m_last_d = 1'b0;
    int            m_cnt = 0;
    logic [AW-1:0] m_q[$];
    int            iv_count = 0;
    int            dv_count = 0;
    int            mdv_all  = 0;
    int            iv_cyc[$];

    initial begin : compare
        logic          e_en, e_wr, e_dv, oreq;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [AW-1:0] ra;
        forever begin
            @(negedge clk);
            if (bus.mem_data_valid) mdv_all++;
            if (bus.i_data_valid) begin
                iv_count++;
                iv_cyc.push_back(cyc);
            end
            if (bus.d_data_valid) dv_count++;
            if (rst) begin
                chk("rst_ctrl", {bus.i_gnt, bus.d_gnt, bus.i_data_valid, bus.d_data_valid,
                                 bus.mem_en, bus.mem_wr}, 0);
                chk("rst_bus", {bus.mem_addr, bus.mem_wdata}, 0);
                chk("rst_rdata", bus.rdata, 0);
                m_owner  = 0;
                m_last_d = 1'b0;
                m_cnt    = 0;
                m_q.delete();
            end else begin
                oreq   = (m_owner == 1) ? bus.i_req : (m_owner == 2) ? bus.d_req : 1'b0;
                e_en   = oreq;
                e_wr   = (m_owner == 2) && bus.d_wr;
                e_addr = (m_owner == 1) ? bus.i_addr : (m_owner == 2) ? bus.d_addr : '0;
                e_wd   = (m_owner == 2) ? bus.d_wdata : '0;
                e_dv   = bus.mem_data_valid && (m_cnt > 0);
                chk("i_gnt", bus.i_gnt, m_owner == 1);
                chk("d_gnt", bus.d_gnt, m_owner == 2);
                chk("mem_en", bus.mem_en, e_en);
                chk("mem_wr", bus.mem_wr, e_wr);
                chk("mem_addr", bus.mem_addr, e_addr);
                chk("mem_wdata", bus.mem_wdata, e_wd);
                chk("i_data_valid", bus.i_data_valid, e_dv && m_owner == 1);
                chk("d_data_valid", bus.d_data_valid, e_dv && m_owner == 2);
                chk("rdata", bus.rdata, bus.mem_rdata);
                chk("out_cnt", dut.out_cnt, m_cnt);
                if (e_dv && m_q.size() != 0) begin
                    ra = m_q.pop_front();
                    chk("rdata_word", bus.rdata, mem_word(ra));
                end
                if (e_en && !e_wr) m_q.push_back(e_addr);
                m_cnt = m_cnt + ((e_en && !e_wr) ? 1 : 0) - (e_dv ? 1 : 0);
                chk("out_cnt_limit", m_cnt <= MO, 1);
                if (m_owner == 0) begin
                    if (bus.i_req && bus.d_req) m_owner = m_last_d ? 1 : 2;
                    else if (bus.d_req)         m_owner = 2;
                    else if (bus.i_req)         m_owner = 1;
                end else if (!oreq && m_cnt == 0) begin
                    m_last_d = (m_owner == 2);
                    m_owner  = 0;
                end
            end
        end
    end

    // ---------------- requester drivers ----------------
    // Raise req, wait for grant, then follow pat (bit j = request in j-th owned cycle).
    task automatic drive(input bit is_d, input bit wr, input logic [AW-1:0] base,
                         input logic [DW-1:0] wd, input logic [15:0] pat, input int len,
                         output int gcyc);
        int n = 0;
        int g = 0;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_wr = wr; bus.d_addr = base; bus.d_wdata = wd;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = base;
        end
        while (!(is_d ? bus.d_gnt : bus.i_gnt) && g < 40) begin
            tick;
            g++;
        end
        chk(is_d ? "d_gnt_wait" : "i_gnt_wait", is_d ? bus.d_gnt : bus.i_gnt, 1);
        gcyc = cyc;
        for (int j = 0; j < len; j++) begin
            if (is_d) begin
                bus.d_req = pat[j];
                if (pat[j]) begin
                    bus.d_addr  = base + AW'(2 * n);
                    bus.d_wdata = wd + DW'(n);
                    n++;
                end
            end else begin
                bus.i_req = pat[j];
                if (pat[j]) begin
                    bus.i_addr = base + AW'(2 * n);
                    n++;
                end
            end
            tick;
        end
        if (is_d) begin
            bus.d_req = 1'b0; bus.d_wr = 1'b0;
        end else begin
            bus.i_req = 1'b0;
        end
    endtask

    task automatic wait_rel(input bit is_d, output int rc);
        int g = 0;
        while ((is_d ? bus.d_gnt : bus.i_gnt) && g < 40) begin
            tick;
            g++;
        end
        chk(is_d ? "d_release" : "i_release", is_d ? bus.d_gnt : bus.i_gnt, 0);
        rc = cyc;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int s, g, gi, gd, r, iv0, dv0, mdv0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        #1;
        chk("init_gnts", {bus.i_gnt, bus.d_gnt, bus.mem_en}, 0);
        tick;
        tick;
        #1 rst = 1'b0;
        tick;

        // I-only block fill of 0x0040..0x004E
        s = cyc; iv0 = iv_count; dv0 = dv_count;
        drive(1'b0, 1'b0, 16'h0040, '0, 16'h00FF, 8, g);
        wait_rel(1'b0, r);
        chk("t1_gnt_lat", g - s, 1);
        chk("t1_iv_cnt", iv_count - iv0, 8);
        chk("t1_first_iv", iv_cyc[iv0] - s, 1 + LAT);
        chk("t1_dv_cnt", dv_count - dv0, 0);
        chk("t1_release", r - s, 13);
        repeat (6) tick;

        // Simultaneous requests with last owner I: D goes first, then one IDLE cycle, then I
        s = cyc; iv0 = iv_count; dv0 = dv_count;
        fork
            drive(1'b1, 1'b0, 16'h0200, '0, 16'h00FF, 8, gd);
            drive(1'b0, 1'b0, 16'h0100, '0, 16'h00FF, 8, gi);
        join
        wait_rel(1'b0, r);
        chk("t2_d_first", gd - s, 1);
        chk("t2_i_after", gi - s, 14);
        chk("t2_iv_cnt", iv_count - iv0, 8);
        chk("t2_dv_cnt", dv_count - dv0, 8);
        repeat (6) tick;

        // Single D write-through
        s = cyc;
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h1234; bus.d_wdata = 16'hBEEF;
        tick;
        chk("t3_gnt", bus.d_gnt, 1);
        #1;
        chk("t3_mem_en", bus.mem_en, 1);
        chk("t3_mem_wr", bus.mem_wr, 1);
        chk("t3_mem_addr", bus.mem_addr, 16'h1234);
        chk("t3_mem_wdata", bus.mem_wdata, 16'hBEEF);
        chk("t3_cnt", dut.out_cnt, 0);
        tick;
        bus.d_req = 1'b0; bus.d_wr = 1'b0;
        chk("t3_hold", bus.d_gnt, 1);
        tick;
        chk("t3_release", bus.d_gnt, 0);
        chk("t3_cnt_after", dut.out_cnt, 0);
        repeat (4) tick;

        // Starvation: D re-requests right after release while I is pending
        s = cyc;
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0300; bus.d_wdata = 16'h1111;
        tick;
        bus.i_req = 1'b1; bus.i_addr = 16'h0400;
        chk("t4_d_gnt", bus.d_gnt, 1);
        tick;
        bus.d_addr = 16'h0302; bus.d_wdata = 16'h2222;
        tick;
        bus.d_req = 1'b0; bus.d_wr = 1'b0;
        tick;
        chk("t4_idle", {bus.i_gnt, bus.d_gnt}, 2'b00);
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0304; bus.d_wdata = 16'h3333;
        tick;
        chk("t4_i_wins", {bus.i_gnt, bus.d_gnt}, 2'b10);
        tick;
        bus.i_addr = 16'h0402;
        tick;
        bus.i_req = 1'b0;
        g = 0;
        while (!bus.d_gnt && g < 40) begin
            tick;
            g++;
        end
        chk("t4_d_regrant", cyc - s, 12);
        tick;
        bus.d_req = 1'b0; bus.d_wr = 1'b0;
        wait_rel(1'b1, r);
        repeat (4) tick;

        // Early drop: D fill with a gap, final drop while two reads are still out
        s = cyc; dv0 = dv_count;
        drive(1'b1, 1'b0, 16'h0600, '0, 16'h063F, 11, g);
        chk("t5_cnt_at_drop", dut.out_cnt, 2);
        chk("t5_gnt_at_drop", bus.d_gnt, 1);
        wait_rel(1'b1, r);
        chk("t5_release", r - s, 16);
        chk("t5_dv_cnt", dv_count - dv0, 8);
        repeat (6) tick;

        // Async reset after 3 of 8 valids; the in-flight responses must be dropped
        iv0 = iv_count; mdv0 = 0;
        fork
            drive(1'b0, 1'b0, 16'h0500, '0, 16'h00FF, 8, g);
            begin
                int w = 0;
                while (iv_count < iv0 + 3 && w < 40) begin
                    tick;
                    w++;
                end
                chk("t6_three_valids", iv_count - iv0, 3);
                #1 rst = 1'b1;
                #1;
                chk("t6_rst_ctrl", {bus.i_gnt, bus.i_data_valid, bus.d_gnt, bus.mem_en}, 0);
                chk("t6_rst_addr", bus.mem_addr, 0);
                chk("t6_rst_rdata", bus.rdata, 0);
                chk("t6_rst_cnt", dut.out_cnt, 0);
                mdv0 = mdv_all;
                iv0  = iv_count;
                tick;
                tick;
                #1 rst = 1'b0;
            end
        join
        repeat (8) tick;
        chk("t6_stray_pulses", mdv_all - mdv0, 4);
        chk("t6_no_iv", iv_count - iv0, 0);
        chk("t6_cnt_after", dut.out_cnt, 0);
        chk("t6_idle", {bus.i_gnt, bus.d_gnt}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
